// File: rtl/ili9341_8080_rx.sv
// Panel-side responder for the ILI9341 8080 8-bit write bus: oversamples the pins,
// decodes commands and CASET/PASET windows, and emits RGB565 pixels with coordinates.
module ili9341_8080_rx #(
    parameter int WIDTH  = 240,
    parameter int HEIGHT = 320
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lcd_rst_n,
    input  logic        lcd_cs_n,
    input  logic        lcd_rs,
    input  logic        lcd_wr_n,
    input  logic        lcd_rd_n,
    input  logic [7:0]  lcd_d,
    output logic        cmd_valid,
    output logic [7:0]  cmd_code,
    output logic        pixel_valid,
    output logic [8:0]  pixel_x,
    output logic [8:0]  pixel_y,
    output logic [15:0] pixel_rgb,
    output logic [8:0]  win_sc,
    output logic [8:0]  win_ec,
    output logic [8:0]  win_sp,
    output logic [8:0]  win_ep,
    output logic        err,
    output logic        rd_seen
);

    localparam logic [8:0]  COL_MAX  = 9'(WIDTH - 1);
    localparam logic [8:0]  ROW_MAX  = 9'(HEIGHT - 1);
    // {lcd_rst_n, cs_n, rs, wr_n, rd_n, d[7:0]} with all strobes idle
    localparam logic [12:0] SYNC_RST = 13'h1B00;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CASET = 3'd1,
        ST_PASET = 3'd2,
        ST_RAMWR = 3'd3,
        ST_SKIP  = 3'd4
    } state_t;

    logic [12:0] sync1_q, sync2_q;
    logic        wr_prev_q, cs_prev_q, rd_prev_q;

    logic        lrst_s, cs_s, rs_s, wr_s, rd_s;
    logic [7:0]  d_s;
    logic        byte_evt_s, cmd_evt_s, data_evt_s, cs_rise_s, rd_fall_s, soft_rst_s;
    logic [8:0]  par_val_s, lim_s;
    logic        bad_win_s;
    logic [8:0]  cur_x_d, cur_y_d;

    state_t      state_q;
    logic        phase_q;
    logic [2:0]  param_cnt_q;
    logic        par_hi_q;
    logic [8:0]  par_start_q;
    logic [7:0]  pix_hi_q;
    logic [8:0]  cur_x_q, cur_y_q;
    logic        cmd_valid_q, pixel_valid_q, err_q, rd_seen_q;
    logic [7:0]  cmd_code_q;
    logic [8:0]  pixel_x_q, pixel_y_q;
    logic [15:0] pixel_rgb_q;
    logic [8:0]  win_sc_q, win_ec_q, win_sp_q, win_ep_q;

    // Two-flop synchroniser on every bus pin plus edge-detect history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= SYNC_RST;
            sync2_q   <= SYNC_RST;
            wr_prev_q <= 1'b1;
            cs_prev_q <= 1'b1;
            rd_prev_q <= 1'b1;
        end else begin
            sync1_q   <= {lcd_rst_n, lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n, lcd_d};
            sync2_q   <= sync1_q;
            wr_prev_q <= wr_s;
            cs_prev_q <= cs_s;
            rd_prev_q <= rd_s;
        end
    end

    assign lrst_s = sync2_q[12];
    assign cs_s   = sync2_q[11];
    assign rs_s   = sync2_q[10];
    assign wr_s   = sync2_q[9];
    assign rd_s   = sync2_q[8];
    assign d_s    = sync2_q[7:0];

    // Bus event decode and window-parameter validation
    always_comb begin
        byte_evt_s = wr_s & ~wr_prev_q & ~cs_s;
        cmd_evt_s  = byte_evt_s & ~rs_s;
        data_evt_s = byte_evt_s & rs_s;
        cs_rise_s  = cs_s & ~cs_prev_q;
        rd_fall_s  = ~rd_s & rd_prev_q & ~cs_s;
        soft_rst_s = ~lrst_s | (cmd_evt_s & (d_s == 8'h01));
        par_val_s  = {par_hi_q, d_s};
        if (state_q == ST_CASET) begin
            lim_s = COL_MAX;
        end else begin
            lim_s = ROW_MAX;
        end
        bad_win_s = (par_start_q > par_val_s) || (par_val_s > lim_s);
    end

    // Cursor advance: raster order inside the window, wrapping to its origin
    always_comb begin
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        if (cur_x_q == win_ec_q) begin
            cur_x_d = win_sc_q;
            if (cur_y_q == win_ep_q) begin
                cur_y_d = win_sp_q;
            end else begin
                cur_y_d = cur_y_q + 9'd1;
            end
        end else begin
            cur_x_d = cur_x_q + 9'd1;
            cur_y_d = cur_y_q;
        end
    end

    // Command/data state machine with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            phase_q       <= 1'b0;
            param_cnt_q   <= 3'd0;
            par_hi_q      <= 1'b0;
            par_start_q   <= 9'd0;
            pix_hi_q      <= 8'd0;
            cur_x_q       <= 9'd0;
            cur_y_q       <= 9'd0;
            cmd_valid_q   <= 1'b0;
            cmd_code_q    <= 8'd0;
            pixel_valid_q <= 1'b0;
            pixel_x_q     <= 9'd0;
            pixel_y_q     <= 9'd0;
            pixel_rgb_q   <= 16'd0;
            win_sc_q      <= 9'd0;
            win_ec_q      <= COL_MAX;
            win_sp_q      <= 9'd0;
            win_ep_q      <= ROW_MAX;
            err_q         <= 1'b0;
            rd_seen_q     <= 1'b0;
        end else begin
            cmd_valid_q   <= 1'b0;
            pixel_valid_q <= 1'b0;
            if (rd_fall_s) begin
                rd_seen_q <= 1'b1;
            end
            if (soft_rst_s) begin
                // Panel reset pin or SWRESET: sticky flags survive
                state_q     <= ST_IDLE;
                phase_q     <= 1'b0;
                param_cnt_q <= 3'd0;
                par_hi_q    <= 1'b0;
                par_start_q <= 9'd0;
                pix_hi_q    <= 8'd0;
                cur_x_q     <= 9'd0;
                cur_y_q     <= 9'd0;
                cmd_code_q  <= 8'd0;
                pixel_x_q   <= 9'd0;
                pixel_y_q   <= 9'd0;
                pixel_rgb_q <= 16'd0;
                win_sc_q    <= 9'd0;
                win_ec_q    <= COL_MAX;
                win_sp_q    <= 9'd0;
                win_ep_q    <= ROW_MAX;
            end else if (cs_rise_s) begin
                phase_q  <= 1'b0;
                pix_hi_q <= 8'd0;
            end else if (cmd_evt_s) begin
                cmd_valid_q <= 1'b1;
                cmd_code_q  <= d_s;
                param_cnt_q <= 3'd0;
                phase_q     <= 1'b0;
                case (d_s)
                    8'h2A:   state_q <= ST_CASET;
                    8'h2B:   state_q <= ST_PASET;
                    8'h2C: begin
                        state_q <= ST_RAMWR;
                        cur_x_q <= win_sc_q;
                        cur_y_q <= win_sp_q;
                    end
                    8'h3C:   state_q <= ST_RAMWR;
                    default: state_q <= ST_SKIP;
                endcase
            end else if (data_evt_s) begin
                case (state_q)
                    ST_IDLE: err_q <= 1'b1;
                    ST_CASET, ST_PASET: begin
                        case (param_cnt_q)
                            3'd0, 3'd2: begin
                                par_hi_q    <= d_s[0];
                                param_cnt_q <= param_cnt_q + 3'd1;
                                if (|d_s[7:1]) begin
                                    err_q <= 1'b1;
                                end
                            end
                            3'd1: begin
                                par_start_q <= par_val_s;
                                param_cnt_q <= 3'd2;
                            end
                            3'd3: begin
                                param_cnt_q <= 3'd4;
                                if (bad_win_s) begin
                                    err_q <= 1'b1;
                                end else if (state_q == ST_CASET) begin
                                    win_sc_q <= par_start_q;
                                    win_ec_q <= par_val_s;
                                end else begin
                                    win_sp_q <= par_start_q;
                                    win_ep_q <= par_val_s;
                                end
                            end
                            default: param_cnt_q <= param_cnt_q;
                        endcase
                    end
                    ST_RAMWR: begin
                        if (!phase_q) begin
                            pix_hi_q <= d_s;
                            phase_q  <= 1'b1;
                        end else begin
                            pixel_valid_q <= 1'b1;
                            pixel_x_q     <= cur_x_q;
                            pixel_y_q     <= cur_y_q;
                            pixel_rgb_q   <= {pix_hi_q, d_s};
                            cur_x_q       <= cur_x_d;
                            cur_y_q       <= cur_y_d;
                            phase_q       <= 1'b0;
                        end
                    end
                    default: state_q <= state_q;
                endcase
            end
        end
    end

    assign cmd_valid   = cmd_valid_q;
    assign cmd_code    = cmd_code_q;
    assign pixel_valid = pixel_valid_q;
    assign pixel_x     = pixel_x_q;
    assign pixel_y     = pixel_y_q;
    assign pixel_rgb   = pixel_rgb_q;
    assign win_sc      = win_sc_q;
    assign win_ec      = win_ec_q;
    assign win_sp      = win_sp_q;
    assign win_ep      = win_ep_q;
    assign err         = err_q;
    assign rd_seen     = rd_seen_q;

endmodule

// File: tb/tb_ili9341_8080_rx.sv
// Directed bench for ili9341_8080_rx: stimulus pushes expected pixels/commands into
// queues and a separate monitor pops and compares whenever the DUT pulses an output.
module tb_ili9341_8080_rx;

    logic        clk;
    logic        rst_n;
    logic        lcd_rst_n;
    logic        lcd_cs_n;
    logic        lcd_rs;
    logic        lcd_wr_n;
    logic        lcd_rd_n;
    logic [7:0]  lcd_d;
    logic        cmd_valid;
    logic [7:0]  cmd_code;
    logic        pixel_valid;
    logic [8:0]  pixel_x, pixel_y;
    logic [15:0] pixel_rgb;
    logic [8:0]  win_sc, win_ec, win_sp, win_ep;
    logic        err, rd_seen;

    int          checks;
    int          failures;
    logic [33:0] pix_q[$];
    logic [7:0]  cmd_q[$];
    time         wr_rise_t;
    time         last_pix_t;

    ili9341_8080_rx #(.WIDTH(240), .HEIGHT(320)) dut (
        .clk(clk), .rst_n(rst_n), .lcd_rst_n(lcd_rst_n), .lcd_cs_n(lcd_cs_n),
        .lcd_rs(lcd_rs), .lcd_wr_n(lcd_wr_n), .lcd_rd_n(lcd_rd_n), .lcd_d(lcd_d),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .pixel_valid(pixel_valid),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_rgb(pixel_rgb),
        .win_sc(win_sc), .win_ec(win_ec), .win_sp(win_sp), .win_ep(win_ep),
        .err(err), .rd_seen(rd_seen)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [33:0] act);
        checks = checks + 1;
        failures = failures + 1;
        $display("FAIL %s: unexpected output %h with nothing expected", name, act);
    endtask

    // Monitor: compares every pulsed output against the scoreboard queues
    initial begin
        logic [33:0] e;
        forever begin
            @(negedge clk);
            if (pixel_valid === 1'b1) begin
                last_pix_t = $time;
                if (pix_q.size() == 0) begin
                    unexpected("pixel", {pixel_x, pixel_y, pixel_rgb});
                end else begin
                    e = pix_q.pop_front();
                    chk("pixel", {pixel_x, pixel_y, pixel_rgb}, e);
                end
            end
            if (cmd_valid === 1'b1) begin
                if (cmd_q.size() == 0) begin
                    unexpected("cmd", 34'(cmd_code));
                end else begin
                    e = 34'(cmd_q.pop_front());
                    chk("cmd", 34'(cmd_code), e);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr_byte(input logic rs, input logic [7:0] b);
        @(negedge clk);
        lcd_cs_n = 1'b0;
        lcd_rs   = rs;
        lcd_d    = b;
        lcd_wr_n = 1'b0;
        repeat (3) @(negedge clk);
        lcd_wr_n  = 1'b1;
        wr_rise_t = $time;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_cmd(input logic [7:0] c);
        if (c != 8'h01) begin
            cmd_q.push_back(c);
        end
        wr_byte(1'b0, c);
    endtask

    task automatic send_data(input logic [7:0] b);
        wr_byte(1'b1, b);
    endtask

    task automatic send_pix(input logic [8:0] x, input logic [8:0] y, input logic [15:0] rgb);
        pix_q.push_back({x, y, rgb});
        send_data(rgb[15:8]);
        send_data(rgb[7:0]);
    endtask

    task automatic send_win(input logic [7:0] c, input logic [15:0] s, input logic [15:0] e);
        send_cmd(c);
        send_data(s[15:8]);
        send_data(s[7:0]);
        send_data(e[15:8]);
        send_data(e[7:0]);
    endtask

    task automatic pulse_rst_n;
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(3);
    endtask

    task automatic chk_win(input string name, input logic [8:0] sc, input logic [8:0] ec,
                           input logic [8:0] sp, input logic [8:0] ep);
        chk(name, {16'd0, win_sc, win_ec}, {16'd0, sc, ec});
        chk(name, {16'd0, win_sp, win_ep}, {16'd0, sp, ep});
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        wr_rise_t  = 0;
        last_pix_t = 0;
        rst_n      = 1'b0;
        lcd_rst_n  = 1'b1;
        lcd_cs_n   = 1'b1;
        lcd_rs     = 1'b0;
        lcd_wr_n   = 1'b1;
        lcd_rd_n   = 1'b1;
        lcd_d      = 8'h00;
        idle(3);
        rst_n = 1'b1;
        idle(4);

        // Reset state
        chk_win("reset_win", 9'd0, 9'd239, 9'd0, 9'd319);
        chk("reset_code", 34'(cmd_code), 34'h0);
        chk("reset_flags", {32'd0, err, rd_seen}, 34'h0);
        chk("reset_pix", {pixel_x, pixel_y, pixel_rgb}, 34'h0);

        // Single pixel in the default window, with latency from the last WR rise
        send_cmd(8'h2C);
        send_pix(9'd0, 9'd0, 16'hF800);
        chk("latency", 34'(last_pix_t - wr_rise_t), 34'd30);

        // 2x2 window with wrap back to the origin
        send_win(8'h2A, 16'd0, 16'd1);
        send_win(8'h2B, 16'd0, 16'd1);
        chk_win("win_2x2", 9'd0, 9'd1, 9'd0, 9'd1);
        send_cmd(8'h2C);
        send_pix(9'd0, 9'd0, 16'hF800);
        send_pix(9'd1, 9'd0, 16'h07E0);
        send_pix(9'd0, 9'd1, 16'h001F);
        send_pix(9'd1, 9'd1, 16'hFFFF);
        send_pix(9'd0, 9'd0, 16'h1234);

        // RAMWRC keeps the cursor, RAMWR restarts it
        send_cmd(8'h3C);
        send_pix(9'd1, 9'd0, 16'hABCD);
        send_cmd(8'h2C);
        send_pix(9'd0, 9'd0, 16'hABCD);
        chk("err_clean", 34'(err), 34'h0);

        // Invalid column window: end 240 out of range
        pulse_rst_n();
        send_win(8'h2A, 16'h0005, 16'h00F0);
        chk("inv_err", 34'(err), 34'h1);
        chk_win("inv_win", 9'd0, 9'd239, 9'd0, 9'd319);

        // Truncated CASET aborted by RAMWR
        pulse_rst_n();
        chk("rst_clr_err", 34'(err), 34'h0);
        send_cmd(8'h2A);
        send_data(8'h00);
        send_data(8'h10);
        send_cmd(8'h2C);
        chk_win("trunc_win", 9'd0, 9'd239, 9'd0, 9'd319);
        chk("trunc_err", 34'(err), 34'h0);

        // CS break drops the pending high byte
        send_cmd(8'h2C);
        send_data(8'hF8);
        lcd_cs_n = 1'b1;
        idle(10);
        send_pix(9'd0, 9'd0, 16'h07E0);

        // Panel reset pin mid-pixel: no pixel, default window, err kept
        pulse_rst_n();
        send_data(8'h55);
        chk("idle_data_err", 34'(err), 34'h1);
        send_win(8'h2A, 16'd0, 16'd9);
        chk_win("pre_lrst_win", 9'd0, 9'd9, 9'd0, 9'd319);
        send_cmd(8'h2C);
        send_data(8'hA5);
        lcd_rst_n = 1'b0;
        idle(6);
        lcd_rst_n = 1'b1;
        idle(4);
        chk_win("lrst_win", 9'd0, 9'd239, 9'd0, 9'd319);
        chk("lrst_err", 34'(err), 34'h1);
        chk("lrst_code", 34'(cmd_code), 34'h0);
        send_cmd(8'h2C);
        send_pix(9'd0, 9'd0, 16'h1357);

        // SWRESET restores the window but keeps err
        send_win(8'h2B, 16'd2, 16'd4);
        chk_win("pre_swr_win", 9'd0, 9'd239, 9'd2, 9'd4);
        send_cmd(8'h01);
        idle(2);
        chk_win("swr_win", 9'd0, 9'd239, 9'd0, 9'd319);
        chk("swr_err", 34'(err), 34'h1);

        // RD strobe: ignored with CS high, flagged with CS low
        lcd_cs_n = 1'b1;
        idle(2);
        lcd_rd_n = 1'b0;
        idle(4);
        lcd_rd_n = 1'b1;
        idle(4);
        chk("rd_cs_high", 34'(rd_seen), 34'h0);
        lcd_cs_n = 1'b0;
        idle(2);
        lcd_rd_n = 1'b0;
        idle(4);
        lcd_rd_n = 1'b1;
        idle(2);
        lcd_cs_n = 1'b1;
        idle(4);
        chk("rd_seen", 34'(rd_seen), 34'h1);
        chk("rd_code", 34'(cmd_code), 34'h0);
        chk("rd_pix", {pixel_x, pixel_y, pixel_rgb}, 34'h0);

        idle(5);
        chk("pix_q_empty", 34'(pix_q.size()), 34'h0);
        chk("cmd_q_empty", 34'(cmd_q.size()), 34'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ili9341_8080_rx.md
Name: ili9341_8080_rx

Overview:
- Responder end of the ILI9341 8080-style 8-bit parallel write bus. It sits on the panel side of the LCD_CS/RS/WR/RD/D[7:0] pins that the VPU LCD driver produces.
- Oversamples the bus in the system clock, then decodes command bytes, CASET/PASET windows and RAMWR/RAMWRC pixel streams.
- Emits one pixel event per RGB565 pair, carrying the decoded x/y coordinates.
- Used as an in-FPGA loopback checker and as the bench-side panel model.

Parameters:
- WIDTH, 240, panel columns; the default column window is 0..WIDTH-1.
- HEIGHT, 320, panel rows; the default page window is 0..HEIGHT-1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- lcd_rst_n  in  1  panel hardware reset pin (asynchronous to clk).
- lcd_cs_n  in  1  chip select, active low.
- lcd_rs  in  1  0=command, 1=data.
- lcd_wr_n  in  1  write strobe; a byte is latched on its rising edge.
- lcd_rd_n  in  1  read strobe; monitored only, never answered.
- lcd_d  in  8  data bus.
- cmd_valid  out  1  one-cycle pulse on each command byte.
- cmd_code  out  8  last command byte.
- pixel_valid  out  1  one-cycle pulse per completed pixel.
- pixel_x  out  9  column of the pixel.
- pixel_y  out  9  row of the pixel.
- pixel_rgb  out  16  RGB565 pixel, high byte first on the bus.
- win_sc, win_ec  out  9 each  active column window.
- win_sp, win_ep  out  9 each  active page window.
- err  out  1  sticky protocol error.
- rd_seen  out  1  sticky flag: a read strobe occurred while CS was low.

Behaviour:
- Input synchronisation:
  - All bus inputs pass through an identical 2-flop synchroniser.
  - A byte event fires in the cycle where the synced wr_n goes 0->1 and the synced cs_n is 0.
  - The byte is taken from the synced lcd_d of the same stage.
  - Bus requirement: WR low and high phases each ≥3 clk; D and RS stable from WR falling until ≥1 clk after WR rising.
- Latency: pixel_valid and cmd_valid assert exactly 1 clk after the byte event, i.e. 3 clk after lcd_wr_n rises at the pin.
- Reset (rst_n low, or synced lcd_rst_n low, or command 0x01 SWRESET):
  - State=IDLE, byte phase=HI.
  - win_sc=0, win_ec=WIDTH-1, win_sp=0, win_ep=HEIGHT-1, cursor=(0,0).
  - All pulse outputs 0; pixel_x/y/rgb=0; cmd_code=0.
  - err and rd_seen are cleared by rst_n only. SWRESET does not clear them.
- Any command byte (RS=0) aborts the current state, sets the parameter counter to 0 and byte phase to HI, then dispatches:
  - 0x2A CASET -> CASET state.
  - 0x2B PASET -> PASET state.
  - 0x2C RAMWR -> cursor=(win_sc,win_sp), then RAMWR state.
  - 0x3C RAMWRC -> RAMWR state with the cursor unchanged.
  - 0x01 SWRESET -> the reset action above.
  - Any other code -> SKIP state; its data bytes are ignored.
- CASET/PASET:
  - Four data bytes: start hi, start lo, end hi, end lo.
  - Value = {hi[0], lo}. A nonzero hi[7:1] sets err.
  - The window updates only after the 4th byte. An aborted partial sequence leaves the window unchanged.
  - Bytes 5+ are ignored and the state stays the same.
  - If start>end, or end ≥ WIDTH (CASET) / HEIGHT (PASET): set err and do not update the window.
- RAMWR data handling:
  - Byte phase HI stores the high byte.
  - Byte phase LO emits pixel_rgb={hi,lo} at the current cursor.
  - The cursor then advances: x==win_ec ? (x=win_sc, y++) : x++.
  - At (win_ec,win_ep) the cursor wraps to (win_sc,win_sp). There is no error on overflow.
- Data byte in IDLE sets err and is otherwise ignored.
- cs_n rising (synced) returns byte phase to HI and drops a pending high byte. State and cursor are kept, so RAMWR continues on the next CS-low.
- RD handling: the synced rd_n falling while cs_n=0 sets rd_seen. The bus is never driven.
- Asynchronous rst_n assertion mid-stream: all state is cleared immediately, and the next byte after release is decoded from IDLE.

Test Plan:
- Default window after rst_n: bytes 2C, F8, 00 -> single pixel_valid with x=0, y=0, rgb=F800, 3 clk after the last WR rise.
- Window 0..1 x 0..1: 2A 00 00 00 01, 2B 00 00 00 01, 2C, then pairs F800, 07E0, 001F, FFFF, 1234.
  - Expected pixels: (0,0)F800, (1,0)07E0, (0,1)001F, (1,1)FFFF, (0,0)1234.
- RAMWRC: after the previous test, 3C then pair ABCD -> pixel at (1,0). Compare: 2C then pair ABCD -> pixel at (0,0).
- Invalid window: 2A 00 05 00 F0 -> err=1, win_sc/win_ec unchanged (0/239).
- Truncated CASET: 2A 00 10 followed by 2C -> window unchanged, err=0.
- CS break: 2C, F8, cs_n high for 10 clk, then 07 E0 -> one pixel with rgb=07E0 at (0,0).
- Reset mid-op: lcd_rst_n pulse low after the high byte of a pixel -> no pixel_valid, windows back to default, err unchanged.
- RD strobe: lcd_rd_n pulse with cs_n low -> rd_seen=1 and no outputs change.
